data_mem_access_ctrl: RTL
=========================

Name: data_mem_access_ctrl

Overview:
- Load/store sequencer sitting directly upstream of the byte-wide data RAM; it drives the RAM's Enable/ReadWrite/Address/DataIn and consumes its DataOut.
- Accepts one byte, halfword or word request from the MEM pipeline stage and breaks it into sequential single-byte RAM cycles, each with a fresh Enable pulse.
- Assembles read bytes big-endian, sign- or zero-extends them, and returns a one-cycle response.
- Flags misaligned, illegal-size and out-of-range requests without touching memory.

Parameters:
- MEM_BYTES, 256, number of addressable bytes in the data RAM; valid byte addresses are 0..MEM_BYTES-1.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request; high only in IDLE
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  input  1  sign-extend byte/halfword loads; ignored for stores and words
- req_addr  input  32  byte address of the first (most significant) byte
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  one-cycle pulse: request complete
- resp_error  output  1  qualified by resp_valid; request rejected
- resp_rdata  output  32  qualified by resp_valid; load result, 0 for stores and errors
- mem_enable  output  1  to RAM Enable
- mem_rw  output  1  to RAM ReadWrite (1 write, 0 read)
- mem_addr  output  32  to RAM Address
- mem_wdata  output  32  to RAM DataIn; byte in [7:0], [31:8] = 0
- mem_rdata  input  32  from RAM DataOut; byte in [7:0], upper bits ignored

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; req_ready = 1.
  - resp_valid, resp_error, mem_enable, mem_rw = 0; resp_rdata, mem_addr, mem_wdata = 0.
  - Byte counter and assembly register = 0.
- Request acceptance:
  - Handshake is req_valid & req_ready, sampled on the rising edge; the request fields are latched.
  - req_valid outside IDLE is ignored. There is no response backpressure.
- Byte count N: 1 for byte, 2 for halfword, 4 for word.
- Error check, evaluated at acceptance. Any of the following is an error:
  - req_size = 11.
  - Halfword with addr[0] != 0.
  - Word with addr[1:0] != 0.
  - req_addr + N - 1 >= MEM_BYTES (compute in 33 bits so there is no wrap).
  - On error: no memory cycle; next state is RESP with resp_error = 1 and resp_rdata = 0.
- FSM states: IDLE, SETUP, STROBE, RESP.
  - IDLE -> SETUP on a good request, with counter i = 0.
  - SETUP (1 cycle):
    - mem_enable = 0.
    - mem_addr = addr + i.
    - mem_rw = write.
    - mem_wdata = store byte i. Big-endian: byte 0 is the most significant byte of the N-byte field (word: [31:24] first; halfword: [15:8] first; byte: [7:0]).
    - Next state: STROBE.
  - STROBE (1 cycle):
    - mem_enable = 1; addr, rw and wdata are held stable.
    - On loads, mem_rdata[7:0] is captured at the closing edge into assembly byte i.
    - If i = N-1, next state is RESP; otherwise i++ and next state is SETUP.
    - Enable returns to 0 in SETUP, so every byte sees a fresh Enable rising edge.
  - RESP (1 cycle):
    - resp_valid = 1.
    - resp_rdata = assembled value, extended per req_signed (byte from bit 7, halfword from bit 15).
    - Next state: IDLE.
- Latency, counted from the acceptance edge:
  - resp_valid is high in cycle 2N+1: byte 3, halfword 5, word 9.
  - Error requests respond in cycle 1.
  - Minimum spacing between accepted requests is 2N+2 cycles, because ready is low in RESP.
- Outputs are registered. mem_addr, mem_wdata and mem_rw hold their last values in IDLE/RESP; mem_enable is 0 outside STROBE.
- Reset mid-operation:
  - Abort; mem_enable drops at once; no response is issued.
  - Bytes already written remain in memory (partial store is not rolled back).

Test Plan:
- Word store 0xA1B2C3D4 @0x10, then word load @0x10 -> four write strobes at 0x10..0x13 carrying A1, B2, C3, D4; load returns resp_rdata = 0xA1B2C3D4 in cycle 9, resp_error = 0.
- Byte store 0x85 @0x20, then byte load @0x20 with signed = 1 and with signed = 0 -> 0xFFFFFF85, then 0x00000085, each in cycle 3.
- Halfword load @0x21 (misaligned), size = 11 @0x00, and word @0xFE with MEM_BYTES = 256 -> resp_error = 1 in cycle 1, resp_rdata = 0, mem_enable never asserted.
- Word store 0x11223344 @0x30 with reset asserted during the third STROBE -> mem_enable 0 immediately, req_ready = 1, no resp_valid. A subsequent word load @0x30 returns 0x1122xxxx: bytes 0x30, 0x31 are written, 0x32, 0x33 are unchanged.
- req_valid held high continuously with back-to-back byte loads -> accepts exactly every 4 cycles; requests presented while busy are dropped, not queued.
- Halfword store 0xBEEF @0x40 -> mem_addr/mem_wdata 0x40/0xBE then 0x41/0xEF. Each strobe is preceded by a SETUP cycle with mem_enable = 0, and addr/data are stable across each STROBE.

Source files
------------

// File: rtl/data_mem_access_ctrl.sv
// Load/store sequencer in front of a byte-wide data RAM. A byte, halfword or
// word request is split into one SETUP/STROBE pair per byte (big-endian,
// most significant byte at the lowest address). Load bytes are assembled,
// sign/zero-extended and returned with a one-cycle response pulse.
// Misaligned, illegal-size and out-of-range requests are rejected without
// touching memory.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE, so req_valid in
// any other state is simply ignored (not queued). resp_valid is a one-cycle
// pulse with no backpressure; resp_error/resp_rdata are meaningful only
// while resp_valid is high.
module data_mem_access_ctrl #(
  parameter int MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] resp_rdata,
  output logic        mem_enable,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]  state_q;
  logic        wr_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  cnt_q;
  logic [23:0] asm_q;

  logic [1:0]  req_last;
  logic [32:0] req_end;
  logic        req_err;
  logic [1:0]  last_q;
  logic [1:0]  next_cnt;
  logic [31:0] assembled;
  logic        rdata_unused;

  // Only the low byte of the RAM read bus carries data.
  assign rdata_unused = ^mem_rdata[31:8];
  assign dbg_state    = state_q;

  // Selects byte k of a right-justified value, k = 0 being bits [7:0].
  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  // Extends a right-justified load value according to its size and signedness.
  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] sz, input logic sg);
    logic [31:0] r;
    case (sz)
      2'b00:   r = {{24{sg & v[7]}}, v[7:0]};
      2'b01:   r = {{16{sg & v[15]}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Request decode: index of the last byte and the rejection conditions.
  // The end address is formed in 33 bits so a request near 2^32 cannot wrap.
  always_comb begin
    req_last = 2'd0;
    case (req_size)
      2'b01:   req_last = 2'd1;
      2'b10:   req_last = 2'd3;
      default: req_last = 2'd0;
    endcase
    req_end = {1'b0, req_addr} + {31'b0, req_last};
    req_err = (req_size == 2'b11)
            | ((req_size == 2'b01) & req_addr[0])
            | ((req_size == 2'b10) & (|req_addr[1:0]))
            | (req_end >= 33'(MEM_BYTES));
  end

  // Per-transfer helpers: last byte index of the latched request, next byte
  // index, and the load value with the byte currently on the RAM bus shifted in.
  always_comb begin
    last_q = 2'd0;
    case (size_q)
      2'b01:   last_q = 2'd1;
      2'b10:   last_q = 2'd3;
      default: last_q = 2'd0;
    endcase
    next_cnt  = cnt_q + 2'd1;
    assembled = {asm_q, mem_rdata[7:0]};
  end

  // Sequencer FSM with registered RAM and response outputs. Byte i of an
  // N-byte store is byte (N-1-i) counted from the LSB of the store data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= 32'h0;
      mem_enable <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      wr_q       <= 1'b0;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      cnt_q      <= 2'd0;
      asm_q      <= 24'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            wr_q      <= req_write;
            size_q    <= req_size;
            signed_q  <= req_signed;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            cnt_q     <= 2'd0;
            asm_q     <= 24'h0;
            req_ready <= 1'b0;
            if (req_err) begin
              state_q    <= ST_RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= 32'h0;
            end else begin
              state_q   <= ST_SETUP;
              mem_addr  <= req_addr;
              mem_rw    <= req_write;
              mem_wdata <= {24'h0, pick_byte(req_wdata, req_last)};
            end
          end
        end
        ST_SETUP: begin
          mem_enable <= 1'b1;
          state_q    <= ST_STROBE;
        end
        ST_STROBE: begin
          mem_enable <= 1'b0;
          if (!wr_q) begin
            asm_q <= assembled[23:0];
          end
          if (cnt_q == last_q) begin
            state_q    <= ST_RESP;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= wr_q ? 32'h0 : extend(assembled, size_q, signed_q);
          end else begin
            cnt_q     <= next_cnt;
            mem_addr  <= addr_q + {30'h0, next_cnt};
            mem_wdata <= {24'h0, pick_byte(wdata_q, last_q - next_cnt)};
            state_q   <= ST_SETUP;
          end
        end
        ST_RESP: begin
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          resp_rdata <= 32'h0;
          req_ready  <= 1'b1;
          state_q    <= ST_IDLE;
        end
        default: begin
          mem_enable <= 1'b0;
          req_ready  <= 1'b1;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
